// File: rtl/axi_frame_reader_pkg.sv
// rtl/axi_frame_reader_pkg.sv - shared AXI encodings, FSM state type and beat-size helper
package axi_frame_reader_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int AXI_ID_W  = 4;
  localparam int AXIS_ID_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int bytes_per_beat(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axi_frame_reader_sync_fifo.sv
// rtl/axi_frame_reader_sync_fifo.sv - single-clock FIFO with full/empty/occupancy outputs
module sync_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_go;
  logic             rd_go;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A write into a full FIFO is only legal when a read frees the slot in the same cycle.
  assign rd_go = rd_en & ~empty;
  assign wr_go = wr_en & (~full | rd_go);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_go) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_go) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_go, rd_go})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/axi_frame_reader.sv
// rtl/axi_frame_reader.sv - reads a frame over AXI4 bursts and streams it out in address order
module axi_frame_reader
  import axi_frame_reader_pkg::*;
#(
  parameter int DATA_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 24,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = 2 * BURST_LEN,
  parameter int AXI_ID       = 0,
  parameter int AXIS_TID     = 0,
  parameter int AXIS_TDEST_W = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       frame_base_i,
  input  logic [CNT_W-1:0]        frame_beats_i,
  input  logic [AXIS_TDEST_W-1:0] tdest_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [AXI_ID_W-1:0]     m_arid_o,
  output logic [ADDR_W-1:0]       m_araddr_o,
  output logic [7:0]              m_arlen_o,
  output logic [2:0]              m_arsize_o,
  output logic [1:0]              m_arburst_o,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  input  logic [AXI_ID_W-1:0]     m_rid_i,
  input  logic [DATA_W-1:0]       m_rdata_i,
  input  logic [1:0]              m_rresp_i,
  input  logic                    m_rlast_i,
  input  logic                    m_rvalid_i,
  output logic                    m_rready_o,
  output logic [AXIS_ID_W-1:0]    m_tid_o,
  output logic [AXIS_TDEST_W-1:0] m_tdest_o,
  output logic [DATA_W-1:0]       m_tdata_o,
  output logic [DATA_W/8-1:0]     m_tkeep_o,
  output logic [DATA_W/8-1:0]     m_tstrb_o,
  output logic                    m_tlast_o,
  output logic                    m_tvalid_o,
  input  logic                    m_tready_i
);

  localparam int BPB         = bytes_per_beat(DATA_W);
  localparam int BURST_BYTES = BURST_LEN * BPB;
  localparam int ALIGN_W     = $clog2(BURST_BYTES);
  localparam int BL_W        = $clog2(BURST_LEN);
  localparam int CW          = $clog2(FIFO_DEPTH + 1);

  state_e                  state;
  state_e                  state_nxt;
  logic [CNT_W-1:0]        beats_q;
  logic [CNT_W-1:0]        ar_left;
  logic [CNT_W-1:0]        out_cnt;
  logic [CW-1:0]           resv;
  logic [BL_W-1:0]         beat_cnt;
  logic [AXIS_TDEST_W-1:0] tdest_q;

  logic                    ar_hs;
  logic                    r_hs;
  logic                    t_hs;
  logic                    start_ok;
  logic                    frame_ok;
  logic                    credit_ok;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic                    unused_ok;

  assign ar_hs    = m_arvalid_o & m_arready_i;
  assign r_hs     = m_rvalid_i & m_rready_o;
  assign t_hs     = m_tvalid_o & m_tready_i;
  assign start_ok = (state == ST_IDLE) & start_i;

  assign frame_ok = (frame_beats_i != '0) &&
                    (frame_beats_i[BL_W-1:0] == '0) &&
                    (frame_base_i[ALIGN_W-1:0] == '0);

  // Space left after every in-flight burst lands must hold a whole new burst.
  assign credit_ok = (int'(fifo_count) + int'(resv) + BURST_LEN) <= FIFO_DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_i) state_nxt = frame_ok ? ST_FETCH : ST_DONE;
      ST_FETCH: if (ar_hs && ar_left == CNT_W'(1)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (t_hs && m_tlast_o) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy_o = (state != ST_IDLE);
  assign done_o = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q     <= '0;
      ar_left     <= '0;
      out_cnt     <= '0;
      resv        <= '0;
      beat_cnt    <= '0;
      tdest_q     <= '0;
      err_o       <= 1'b0;
      m_arvalid_o <= 1'b0;
      m_araddr_o  <= '0;
    end else if (start_ok) begin
      beats_q    <= frame_beats_i;
      tdest_q    <= tdest_i;
      m_araddr_o <= frame_base_i;
      ar_left    <= frame_ok ? (frame_beats_i >> BL_W) : '0;
      err_o      <= ~frame_ok;
      out_cnt    <= '0;
      resv       <= '0;
      beat_cnt   <= '0;
    end else begin
      if (state == ST_FETCH && !m_arvalid_o && ar_left != '0 && credit_ok)
        m_arvalid_o <= 1'b1;
      if (ar_hs) begin
        m_arvalid_o <= 1'b0;
        m_araddr_o  <= m_araddr_o + ADDR_W'(BURST_BYTES);
        ar_left     <= ar_left - CNT_W'(1);
      end
      resv <= resv + (ar_hs ? CW'(BURST_LEN) : '0) - (r_hs ? CW'(1) : '0);
      if (r_hs) begin
        beat_cnt <= (beat_cnt == BL_W'(BURST_LEN - 1)) ? '0 : beat_cnt + 1'b1;
        if (m_rresp_i != AXI_RESP_OKAY) err_o <= 1'b1;
        if (m_rlast_i != (beat_cnt == BL_W'(BURST_LEN - 1))) err_o <= 1'b1;
      end
      if (t_hs) out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  assign m_arid_o    = AXI_ID_W'(AXI_ID);
  assign m_arlen_o   = 8'(BURST_LEN - 1);
  assign m_arsize_o  = 3'($clog2(BPB));
  assign m_arburst_o = AXI_BURST_INCR;
  assign m_rready_o  = (resv != '0);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (r_hs),
    .wr_data (m_rdata_i),
    .rd_en   (t_hs),
    .rd_data (m_tdata_o),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m_tvalid_o = ~fifo_empty;
  assign m_tlast_o  = m_tvalid_o && (out_cnt == beats_q - CNT_W'(1));
  assign m_tkeep_o  = '1;
  assign m_tstrb_o  = '1;
  assign m_tid_o    = AXIS_ID_W'(AXIS_TID);
  assign m_tdest_o  = tdest_q;

  assign unused_ok = &{1'b0, m_rid_i, fifo_full};

endmodule

// File: tb/tb_axi_frame_reader.sv
// tb/tb_axi_frame_reader.sv - directed bench with an AXI4 read slave model and stream scoreboard
module tb_axi_frame_reader;
  import axi_frame_reader_pkg::*;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 24;
  localparam int BL     = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  start_i;
  logic [ADDR_W-1:0]     frame_base_i;
  logic [CNT_W-1:0]      frame_beats_i;
  logic [0:0]            tdest_i;
  logic                  busy_o, done_o, err_o;
  logic [AXI_ID_W-1:0]   m_arid_o;
  logic [ADDR_W-1:0]     m_araddr_o;
  logic [7:0]            m_arlen_o;
  logic [2:0]            m_arsize_o;
  logic [1:0]            m_arburst_o;
  logic                  m_arvalid_o, m_arready_i;
  logic [AXI_ID_W-1:0]   m_rid_i;
  logic [DATA_W-1:0]     m_rdata_i;
  logic [1:0]            m_rresp_i;
  logic                  m_rlast_i, m_rvalid_i, m_rready_o;
  logic [AXIS_ID_W-1:0]  m_tid_o;
  logic [0:0]            m_tdest_o;
  logic [DATA_W-1:0]     m_tdata_o;
  logic [DATA_W/8-1:0]   m_tkeep_o, m_tstrb_o;
  logic                  m_tlast_o, m_tvalid_o, m_tready_i;

  axi_frame_reader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .frame_base_i(frame_base_i),
    .frame_beats_i(frame_beats_i), .tdest_i(tdest_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o),
    .m_arsize_o(m_arsize_o), .m_arburst_o(m_arburst_o), .m_arvalid_o(m_arvalid_o),
    .m_arready_i(m_arready_i), .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i), .m_rvalid_i(m_rvalid_i),
    .m_rready_o(m_rready_o), .m_tid_o(m_tid_o), .m_tdest_o(m_tdest_o),
    .m_tdata_o(m_tdata_o), .m_tkeep_o(m_tkeep_o), .m_tstrb_o(m_tstrb_o),
    .m_tlast_o(m_tlast_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_base;
  int          exp_beats;
  logic [0:0]  exp_tdest;
  int t_idx, r_count, ar_count, done_cnt, arv_cycles, rbeat;
  int ar_stall = 0, tready_hold = 0, slverr_idx = -1, rlast_bad_idx = -1;
  logic [31:0] ar_q [$];
  bit   err_chk = 0;
  logic prev_arvalid = 0, prev_arready = 0;
  logic [31:0] prev_araddr = '0;

  function automatic logic [DATA_W-1:0] beat_data(input logic [31:0] a);
    return {8{a}};
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AXI read slave and stream scoreboard: observe at negedge, drive just after posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (err_chk) begin check("err_next_cycle", err_o, 1); err_chk = 0; end
      if (m_arvalid_o) arv_cycles++;
      if (rst_n && prev_arvalid && !prev_arready) begin
        check("ar_hold_valid", m_arvalid_o, 1);
        check("ar_hold_addr", m_araddr_o, prev_araddr);
      end
      if (m_arvalid_o && !prev_arvalid)
        check("ar_credit", (int'(dut.u_fifo.count) + ar_count*BL - r_count + BL) <= 32, 1);
      check("fifo_max", int'(dut.u_fifo.count) <= 32, 1);
      if (m_arvalid_o && m_arready_i) begin
        check("araddr", m_araddr_o, exp_base + 32'(ar_count) * 32'd512);
        check("arlen", m_arlen_o, 8'd15);
        check("arsize", m_arsize_o, 3'd5);
        check("arburst", m_arburst_o, 2'b01);
        check("arid", m_arid_o, '0);
        ar_q.push_back(m_araddr_o);
        ar_count++;
      end
      if (m_rvalid_i && m_rready_o) begin
        if (m_rresp_i != AXI_RESP_OKAY) err_chk = 1;
        r_count++;
        rbeat = (rbeat + 1) % BL;
        if (rbeat == 0) void'(ar_q.pop_front());
      end
      if (m_tvalid_o && m_tready_i) begin
        check("tdata", m_tdata_o, beat_data(exp_base + 32'(t_idx) * 32'd32));
        check("tlast", m_tlast_o, t_idx == exp_beats - 1);
        check("tkeep", {m_tkeep_o, m_tstrb_o}, {64{1'b1}});
        check("tdest", m_tdest_o, exp_tdest);
        check("tid", m_tid_o, '0);
        t_idx++;
      end
      if (done_o) done_cnt++;
      prev_arvalid = m_arvalid_o;
      prev_arready = m_arready_i;
      prev_araddr  = m_araddr_o;
      @(posedge clk);
      #1;
      m_arready_i = (ar_stall == 0);
      if (ar_stall > 0) ar_stall--;
      m_tready_i = (tready_hold == 0);
      if (tready_hold > 0) tready_hold--;
      if (ar_q.size() > 0) begin
        m_rvalid_i = 1'b1;
        m_rdata_i  = beat_data(ar_q[0] + 32'(rbeat) * 32'd32);
        m_rlast_i  = (rbeat == BL - 1) ^ (r_count == rlast_bad_idx);
        m_rresp_i  = (r_count == slverr_idx) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else begin
        m_rvalid_i = 1'b0;
        m_rlast_i  = 1'b0;
        m_rresp_i  = AXI_RESP_OKAY;
      end
    end
  end

  task automatic start_frame(input logic [31:0] base, input int beats, input logic [0:0] td);
    @(posedge clk);
    #2;
    exp_base = base; exp_beats = beats; exp_tdest = td;
    t_idx = 0; r_count = 0; ar_count = 0; done_cnt = 0; arv_cycles = 0;
    frame_base_i = base; frame_beats_i = CNT_W'(beats); tdest_i = td;
    start_i = 1'b1;
    @(posedge clk);
    #2;
    start_i = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] base, input int beats, input logic [0:0] td,
                           input bit bad_cfg, input bit exp_err, input int stall_at, input bit poke);
    int  n;
    bit  seen;
    int  stall;
    n = 0; seen = 0; stall = stall_at;
    start_frame(base, beats, td);
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (done_o) seen = 1;
      if (stall >= 0 && t_idx >= stall) begin tready_hold = 40; stall = -1; end
      if (poke && n == 3) begin start_i = 1'b1; frame_base_i = 32'h8000; frame_beats_i = 16; end
      if (poke && n == 4) start_i = 1'b0;
    end
    check("done_seen", seen, 1);
    if (bad_cfg) check("done_fast", n <= 2, 1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("err", err_o, exp_err);
    check("busy_after", busy_o, 0);
    check("beats_out", t_idx, bad_cfg ? 0 : beats);
    check("ar_count", ar_count, bad_cfg ? 0 : beats / BL);
    if (bad_cfg) check("no_arvalid", arv_cycles, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start_i = 1'b0; frame_base_i = '0; frame_beats_i = '0; tdest_i = '0;
    m_arready_i = 1'b0; m_rid_i = '0; m_rdata_i = '0; m_rresp_i = '0; m_rlast_i = 1'b0;
    m_rvalid_i = 1'b0; m_tready_i = 1'b0;
    exp_base = '0; exp_beats = 0; exp_tdest = '0;
    t_idx = 0; r_count = 0; ar_count = 0; done_cnt = 0; arv_cycles = 0; rbeat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_arvalid", m_arvalid_o, 0);
    check("rst_rready", m_rready_o, 0);
    check("rst_tvalid", m_tvalid_o, 0);
    check("rst_tlast", m_tlast_o, 0);
    check("rst_araddr", m_araddr_o, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    run_frame(32'h1000, 64, 1'b1, 0, 0, -1, 0);
    run_frame(32'h2000, 64, 1'b0, 0, 0, 10, 0);
    slverr_idx = 5;
    run_frame(32'h4000, 64, 1'b0, 0, 1, -1, 0);
    slverr_idx = -1;
    run_frame(32'h1000, 20, 1'b0, 1, 1, -1, 0);
    run_frame(32'h1010, 64, 1'b0, 1, 1, -1, 0);
    ar_stall = 8;
    run_frame(32'h6000, 64, 1'b1, 0, 0, -1, 1);
    rlast_bad_idx = 3;
    run_frame(32'h5000, 32, 1'b0, 0, 1, -1, 0);
    rlast_bad_idx = -1;

    start_frame(32'h3000, 64, 1'b1);
    n = 0;
    while (!(ar_count == 4 && t_idx >= 50) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_reached", n < 2000, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    ar_q.delete(); rbeat = 0; m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_err", err_o, 0);
    check("mid_rst_arvalid", m_arvalid_o, 0);
    check("mid_rst_rready", m_rready_o, 0);
    check("mid_rst_tvalid", m_tvalid_o, 0);
    check("mid_rst_tlast", m_tlast_o, 0);
    check("mid_rst_araddr", m_araddr_o, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_frame(32'h1000, 32, 1'b1, 0, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
